// File: rtl/spmv_mem_arb.sv
// Round-robin arbiter that shares one DCP memory port among the SpMV fetch engines.
// Tags each transid with the requester ID, limits in-flight requests and routes responses back.
module spmv_mem_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TID_W   = 6,
  parameter int TAG_W   = 4,
  parameter int PADDR_W = 40,
  parameter int DATA_W  = 512,
  parameter int MAX_OUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_val,
  output logic [NUM_REQ-1:0]         req_rdy,
  input  logic [NUM_REQ*PADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic                       mem_req_val,
  input  logic                       mem_req_rdy,
  output logic [PADDR_W-1:0]         mem_req_addr,
  output logic [TID_W-1:0]           mem_req_transid,
  input  logic                       mem_resp_val,
  input  logic [TID_W-1:0]           mem_resp_transid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic [NUM_REQ-1:0]         resp_val,
  output logic [TAG_W-1:0]           resp_tag,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       idle,
  output logic                       err
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [CW-1:0]      cnt_d [NUM_REQ];
  logic [NUM_REQ-1:0] elig;
  logic [ID_W-1:0]    grant;
  logic [ID_W-1:0]    resp_id;
  logic [TAG_W-1:0]   grant_tag;
  logic               found;
  logic               hsk;
  logic               resp_ok;
  int                 idx;

  // A stalled grant stays locked so the address presented to DCP cannot change under it.
  always_comb begin
    elig  = '0;
    grant = lock_id_q;
    found = lock_q;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_val[i] && (cnt_q[i] < CW'(MAX_OUT));
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && elig[i]) begin
          grant = ID_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_req_addr = '0;
    grant_tag    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        mem_req_addr = req_addr[i*PADDR_W +: PADDR_W];
        grant_tag    = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign mem_req_val     = found;
  assign mem_req_transid = {grant, grant_tag};
  assign hsk             = mem_req_val && mem_req_rdy;

  // A response is legal only for a requester with something in flight, counting a same-cycle issue.
  always_comb begin
    resp_id  = mem_resp_transid[TID_W-1:TAG_W];
    resp_ok  = 1'b0;
    req_rdy  = '0;
    resp_val = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = hsk && (grant == ID_W'(i));
      if ((resp_id == ID_W'(i)) && ((cnt_q[i] != '0) || req_rdy[i])) resp_ok = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_val[i] = mem_resp_val && resp_ok && (resp_id == ID_W'(i));
    end
  end

  assign resp_tag  = mem_resp_transid[TAG_W-1:0];
  assign resp_data = mem_resp_data;
  assign err       = err_q;

  always_comb begin
    idle = !mem_req_val;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_q[i] != '0) idle = 1'b0;
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q || (mem_resp_val && !resp_ok);
    if (hsk) begin
      ptr_d  = (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
      lock_d = 1'b0;
    end else if (mem_req_val) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_rdy[i] && !resp_val[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (resp_val[i] && !req_rdy[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
